// File: rtl/sequence_playback_ctrl.sv
// sequence_playback_ctrl
// Paints the board at power-up. Then, on start, fills a sequence buffer from a
// free-running LFSR and plays it back. Each step flashes a tile, holds it,
// restores its base colour and waits a gap. The LOAD/DRAW strobes drive the
// existing tile datapath.
// Optional build macro SEQ_REPLAY_EN adds a `replay` input. It replays the
// stored sequence without regenerating it.
// The first clock edge after resetn deasserts arms the controller. The strobes
// therefore stay low while reset is held, and the first ld_tile pulse follows
// that arming edge.
module sequence_playback_ctrl #(
    parameter  int NUM_TILES    = 4,
    parameter  int MAX_SEQ      = 16,
    parameter  int TILE_PIX     = 64,
    parameter  int FLASH_CYCLES = 25000000,
    parameter  int GAP_CYCLES   = 12500000,
    localparam int TW = (NUM_TILES > 1) ? $clog2(NUM_TILES) : 1,
    localparam int SW = $clog2(MAX_SEQ + 1),
    localparam int PW = (TILE_PIX > 1) ? $clog2(TILE_PIX) : 1
) (
    input  logic          clock,
    input  logic          resetn,
    input  logic          start,
`ifdef SEQ_REPLAY_EN
    input  logic          replay,
`endif
    input  logic [SW-1:0] seq_len,
    output logic [TW-1:0] tile_num,
    output logic          ld_tile,
    output logic          ld_flash,
    output logic          ld_restore,
    output logic          write_en,
    output logic [PW-1:0] pix_count,
    output logic [SW-1:0] seq_index,
    output logic          busy,
    output logic          done
);

    localparam int IW = (MAX_SEQ > 1) ? $clog2(MAX_SEQ) : 1;
    localparam int HW = (FLASH_CYCLES > 1) ? $clog2(FLASH_CYCLES) : 1;
    localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    localparam logic [3:0] BOOT_LOAD = 4'd0;
    localparam logic [3:0] BOOT_DRAW = 4'd1;
    localparam logic [3:0] IDLE      = 4'd2;
    localparam logic [3:0] GEN       = 4'd3;
    localparam logic [3:0] PB_LOAD_F = 4'd4;
    localparam logic [3:0] PB_DRAW_F = 4'd5;
    localparam logic [3:0] PB_HOLD   = 4'd6;
    localparam logic [3:0] PB_LOAD_R = 4'd7;
    localparam logic [3:0] PB_DRAW_R = 4'd8;
    localparam logic [3:0] PB_GAP    = 4'd9;
    localparam logic [3:0] DONE      = 4'd10;

    logic [3:0]    state_q, state_d;
    logic          armed_q, armed_d;
    logic [TW-1:0] tile_q, tile_d;
    logic [PW-1:0] pix_q, pix_d;
    logic [SW-1:0] seq_idx_q, seq_idx_d;
    logic [SW-1:0] len_q, len_d;
    logic [HW-1:0] hold_q, hold_d;
    logic [GW-1:0] gap_q, gap_d;
    logic [15:0]   lfsr_q, lfsr_d;
    logic [TW-1:0] seq_buf_q [MAX_SEQ];
    logic          buf_we;

    logic [TW-1:0] lfsr_low;
    logic [TW-1:0] gen_val;
    logic [SW-1:0] req_len;
    logic [SW-1:0] next_idx;
    logic          pix_last;
    logic          step_last;

    // Derived values: the tile index reduced into range, the clamped length and step bookkeeping.
    always_comb begin
        lfsr_low  = lfsr_q[TW-1:0];
        gen_val   = ({1'b0, lfsr_low} >= (TW+1)'(NUM_TILES)) ? lfsr_low - TW'(NUM_TILES) : lfsr_low;
        req_len   = (seq_len > SW'(MAX_SEQ)) ? SW'(MAX_SEQ) : seq_len;
        next_idx  = seq_idx_q + SW'(1);
        pix_last  = (pix_q == PW'(TILE_PIX - 1));
        step_last = (seq_idx_q == len_q - SW'(1));
        // Fibonacci LFSR, taps 16,14,13,11, shifting toward bit 0.
        lfsr_d    = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};
    end

    // Next-state and counter logic for boot paint, generation and playback.
    always_comb begin
        // NOTE: every signal gets a default first, so no path through the case can infer a latch.
        state_d   = state_q;
        armed_d   = 1'b1;
        tile_d    = tile_q;
        pix_d     = '0;
        seq_idx_d = seq_idx_q;
        len_d     = len_q;
        hold_d    = '0;
        gap_d     = '0;
        buf_we    = 1'b0;
        case (state_q)
            BOOT_LOAD: if (armed_q) state_d = BOOT_DRAW;
            BOOT_DRAW: begin
                pix_d = pix_q + PW'(1);
                if (pix_last) begin
                    pix_d = '0;
                    if (tile_q == TW'(NUM_TILES - 1)) begin
                        tile_d  = '0;
                        state_d = IDLE;
                    end else begin
                        tile_d  = tile_q + TW'(1);
                        state_d = BOOT_LOAD;
                    end
                end
            end
            IDLE: begin
                if (start) begin
                    len_d     = req_len;
                    seq_idx_d = '0;
                    state_d   = (req_len == '0) ? DONE : GEN;
                end
`ifdef SEQ_REPLAY_EN
                else if (replay && len_q != '0) begin
                    seq_idx_d = '0;
                    tile_d    = seq_buf_q[0];
                    state_d   = PB_LOAD_F;
                end
`endif
            end
            GEN: begin
                buf_we = 1'b1;
                if (step_last) begin
                    seq_idx_d = '0;
                    // When len is 1, entry 0 is being written this cycle, so bypass the buffer.
                    tile_d    = (seq_idx_q == '0) ? gen_val : seq_buf_q[0];
                    state_d   = PB_LOAD_F;
                end else begin
                    seq_idx_d = next_idx;
                end
            end
            PB_LOAD_F: state_d = PB_DRAW_F;
            PB_DRAW_F: begin
                pix_d = pix_q + PW'(1);
                if (pix_last) state_d = PB_HOLD;
            end
            PB_HOLD: begin
                hold_d = hold_q + HW'(1);
                if (hold_q == HW'(FLASH_CYCLES - 1)) begin
                    hold_d  = '0;
                    state_d = PB_LOAD_R;
                end
            end
            PB_LOAD_R: state_d = PB_DRAW_R;
            PB_DRAW_R: begin
                pix_d = pix_q + PW'(1);
                if (pix_last) state_d = PB_GAP;
            end
            PB_GAP: begin
                gap_d = gap_q + GW'(1);
                if (gap_q == GW'(GAP_CYCLES - 1)) begin
                    gap_d = '0;
                    if (step_last) begin
                        state_d = DONE;
                    end else begin
                        seq_idx_d = next_idx;
                        tile_d    = seq_buf_q[next_idx[IW-1:0]];
                        state_d   = PB_LOAD_F;
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = BOOT_LOAD;
        endcase
    end

    // State and counter registers.
    always_ff @(posedge clock or negedge resetn) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
        if (!resetn) begin
            state_q   <= BOOT_LOAD;
            armed_q   <= 1'b0;
            tile_q    <= '0;
            pix_q     <= '0;
            seq_idx_q <= '0;
            len_q     <= '0;
            hold_q    <= '0;
            gap_q     <= '0;
            lfsr_q    <= 16'hACE1;
        end else begin
            state_q   <= state_d;
            armed_q   <= armed_d;
            tile_q    <= tile_d;
            pix_q     <= pix_d;
            seq_idx_q <= seq_idx_d;
            len_q     <= len_d;
            hold_q    <= hold_d;
            gap_q     <= gap_d;
            lfsr_q    <= lfsr_d;
        end
    end

    // Sequence buffer write port.
    always_ff @(posedge clock) begin
        // NOTE: the buffer has no reset. Every entry that is read is first written by GEN.
        if (buf_we) seq_buf_q[seq_idx_q[IW-1:0]] <= gen_val;
    end

    // Outputs are decoded from registered state only.
    always_comb begin
        tile_num   = tile_q;
        pix_count  = pix_q;
        seq_index  = seq_idx_q;
        ld_tile    = (state_q == BOOT_LOAD) && armed_q;
        ld_flash   = (state_q == PB_LOAD_F);
        ld_restore = (state_q == PB_LOAD_R);
        write_en   = (state_q == BOOT_DRAW) || (state_q == PB_DRAW_F) || (state_q == PB_DRAW_R);
        busy       = (state_q != IDLE);
        done       = (state_q == DONE);
    end

endmodule

// File: tb/tb_sequence_playback_ctrl.sv
// Randomized self-checking bench for sequence_playback_ctrl.
// It uses a small configuration: 4 tiles, an 8-deep buffer, 4 pixels per tile, hold 3 and gap 2.
// Define SEQ_REPLAY_EN to also exercise the replay input.
module tb_sequence_playback_ctrl;

    localparam int NT   = 4;
    localparam int MS   = 8;
    localparam int TP   = 4;
    localparam int FC   = 3;
    localparam int GC   = 2;
    localparam int STEP = 2 + 2*TP + FC + GC;
    localparam int BOOT = NT * (1 + TP);

    logic       clock = 1'b0;
    logic       resetn = 1'b0;
    logic       start = 1'b0;
    logic [3:0] seq_len = '0;
`ifdef SEQ_REPLAY_EN
    logic       replay = 1'b0;
`endif
    logic [1:0] tile_num;
    logic       ld_tile, ld_flash, ld_restore, write_en, busy, done;
    logic [1:0] pix_count;
    logic [3:0] seq_index;

    int total = 0;
    int bad   = 0;

    int last_tiles[$];
    int last_len = 0;

    sequence_playback_ctrl #(
        .NUM_TILES(NT), .MAX_SEQ(MS), .TILE_PIX(TP), .FLASH_CYCLES(FC), .GAP_CYCLES(GC)
    ) dut (
        .clock(clock), .resetn(resetn), .start(start),
`ifdef SEQ_REPLAY_EN
        .replay(replay),
`endif
        .seq_len(seq_len), .tile_num(tile_num), .ld_tile(ld_tile), .ld_flash(ld_flash),
        .ld_restore(ld_restore), .write_en(write_en), .pix_count(pix_count),
        .seq_index(seq_index), .busy(busy), .done(done)
    );

    always #5 clock = ~clock;

    // Advance the 16-bit LFSR by one step, with taps 16,14,13,11.
    function automatic logic [15:0] lfsr_next(input logic [15:0] v);
        logic [15:0] b;
        b = (v ^ (v >> 2) ^ (v >> 3) ^ (v >> 5)) & 16'h0001;
        return (v >> 1) | (b << 15);
    endfunction

    // Map an LFSR value to a tile index: low TW bits, folded into 0..NT-1.
    function automatic int tile_of(input logic [15:0] v);
        int t;
        t = int'(v) % (1 << $clog2(NT));
        if (t >= NT) t = t - NT;
        return t;
    endfunction

    // Reference LFSR. It steps on every clock edge that is out of reset.
    logic [15:0] m_lfsr;
    always @(posedge clock or negedge resetn) begin
        if (!resetn) m_lfsr <= 16'hACE1;
        else         m_lfsr <= lfsr_next(m_lfsr);
    end

    task automatic check(input string tag, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    function automatic int out_vec();
        return int'({ld_tile, ld_flash, ld_restore, write_en, done, busy, pix_count, tile_num});
    endfunction

    // Hold reset, check the reset outputs, release reset and check the full board paint.
    task automatic do_boot();
        int e, p, t, r;
        repeat (2) @(negedge clock);
        check("reset_outputs", out_vec(), 16);
        check("reset_seq_index", int'(seq_index), 0);
        resetn = 1'b1;
        for (int k = 1; k <= BOOT + 1; k++) begin
            @(negedge clock);
            if (k <= BOOT) begin
                p = k - 1;
                t = p / (1 + TP);
                r = p % (1 + TP);
                e = ((r == 0) ? 512 : 64) + 16 + ((r == 0) ? 0 : (r - 1)) * 4 + t;
                check($sformatf("boot_cycle%0d", k), out_vec(), e);
            end else begin
                check("boot_idle", out_vec() & 10'h3FC, 0);
            end
        end
    endtask

    // One start (or replay) transaction, compared against the expected tile list and timing.
    task automatic run_playback(input int req, input bit noise, input bit use_replay);
        int eff, done_cyc, idx_at_done, nw, pos, pixbad, exp_done;
        logic [15:0] l;
        int exp_t[$];
        int got_f[$];
        int got_r[$];
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 400 && !seen; i++) begin
            @(negedge clock);
            if (!busy) seen = 1'b1;
        end
        check("idle_wait", int'(seen), 1);
        if (!seen) return;
        if (use_replay) begin
            eff   = last_len;
            exp_t = last_tiles;
`ifdef SEQ_REPLAY_EN
            replay = 1'b1;
`endif
        end else begin
            eff     = (req > MS) ? MS : req;
            seq_len = 4'(req);
            start   = 1'b1;
            l       = m_lfsr;
            for (int i = 0; i < eff; i++) begin
                l = lfsr_next(l);
                exp_t.push_back(tile_of(l));
            end
        end
        done_cyc = -1; idx_at_done = -1; nw = 0; pos = 0; pixbad = 0;
        for (int cyc = 1; cyc <= 2000; cyc++) begin
            @(negedge clock);
            if (ld_flash)   got_f.push_back(int'(tile_num));
            if (ld_restore) got_r.push_back(int'(tile_num));
            if (write_en) begin
                if (int'(pix_count) != pos) pixbad++;
                pos++;
                nw++;
            end else begin
                pos = 0;
            end
`ifdef SEQ_REPLAY_EN
            replay = 1'b0;
`endif
            if (done) begin
                done_cyc    = cyc;
                idx_at_done = int'(seq_index);
                start       = 1'b0;
                break;
            end
            start = (noise && busy) ? 1'($urandom_range(0, 1)) : 1'b0;
            if (noise) seq_len = 4'($urandom_range(0, 15));
        end
        exp_done = use_replay ? (1 + eff*STEP) : ((eff == 0) ? 1 : (1 + eff + eff*STEP));
        check($sformatf("done_latency_len%0d", req), done_cyc, exp_done);
        check("flash_count", got_f.size(), eff);
        check("restore_count", got_r.size(), eff);
        check("write_count", nw, 2*TP*eff);
        check("pix_sequence_errors", pixbad, 0);
        for (int i = 0; i < eff && i < got_f.size(); i++)
            check($sformatf("flash_tile%0d", i), got_f[i], exp_t[i]);
        for (int i = 0; i < eff && i < got_r.size(); i++)
            check($sformatf("restore_tile%0d", i), got_r[i], exp_t[i]);
        if (eff > 0) check("final_seq_index", idx_at_done, eff - 1);
        @(negedge clock);
        check("busy_after_done", int'(busy), 0);
        check("done_one_cycle", int'(done), 0);
        if (!use_replay) begin
            last_tiles = exp_t;
            last_len   = eff;
        end
    endtask

    // Assert reset during the second step of a 5-step playback, then check the repaint.
    task automatic reset_mid_playback();
        int nf;
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 400 && !seen; i++) begin
            @(negedge clock);
            if (!busy) seen = 1'b1;
        end
        check("idle_wait_mid", int'(seen), 1);
        seq_len = 4'd5;
        start   = 1'b1;
        nf = 0;
        for (int i = 0; i < 500 && nf < 2; i++) begin
            @(negedge clock);
            start = 1'b0;
            if (ld_flash) nf++;
        end
        check("second_step_reached", nf, 2);
        repeat (3) @(negedge clock);
        resetn = 1'b0;
        #1;
        check("midreset_outputs", out_vec(), 16);
        check("midreset_seq_index", int'(seq_index), 0);
        do_boot();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        do_boot();
        run_playback(3, 1'b0, 1'b0);
`ifdef SEQ_REPLAY_EN
        run_playback(0, 1'b0, 1'b1);
`endif
        run_playback(12, 1'b0, 1'b0);
        run_playback(0, 1'b0, 1'b0);
        run_playback(1, 1'b0, 1'b0);
        run_playback(3, 1'b1, 1'b0);
        reset_mid_playback();
        run_playback(2, 1'b0, 1'b0);
        for (int n = 0; n < 5; n++)
            run_playback($urandom_range(0, 15), 1'($urandom_range(0, 1)), 1'b0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
